// File: rtl/uc_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Fixed opcodes in the 11xxxx control-flow class
    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_NOP  = 6'b110011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Class masks: ALU register ops are 0xxxxx, load-immediate is 10xxxx
    localparam logic [5:0] MASK_ALU = 6'b100000;
    localparam logic [5:0] PAT_ALU  = 6'b000000;
    localparam logic [5:0] MASK_LI  = 6'b110000;
    localparam logic [5:0] PAT_LI   = 6'b100000;

    // ALU pass-through of the immediate operand
    localparam logic [2:0] ALUOP_LI = 3'b111;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we;
        logic       wez;
        logic [2:0] alu_op;
        logic       pc_we;
    } ctrl_t;

    // Safe vector: PC+1 selected, no writes anywhere
    localparam ctrl_t CTRL_DEFAULT = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0,
                                       wez: 1'b0, alu_op: 3'b000, pc_we: 1'b0};

    function automatic logic op_match(input logic [5:0] op,
                                      input logic [5:0] mask,
                                      input logic [5:0] pat);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational opcode/zero decode into a datapath control vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent qualifies the vector with the EXEC state.
// Ports: opcode/zero in; ctrl vector, illegal_op and halt_op flags out.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic       illegal_op,
    output logic       halt_op
);

    always_comb begin
        ctrl       = CTRL_DEFAULT;
        illegal_op = 1'b0;
        halt_op    = 1'b0;
        if (op_match(opcode, MASK_ALU, PAT_ALU)) begin
            ctrl.alu_op = opcode[4:2];
            ctrl.we     = 1'b1;
            ctrl.wez    = 1'b1;
            ctrl.pc_we  = 1'b1;
        end else if (op_match(opcode, MASK_LI, PAT_LI)) begin
            ctrl.alu_op = ALUOP_LI;
            ctrl.s_inm  = 1'b1;
            ctrl.we     = 1'b1;
            ctrl.pc_we  = 1'b1;
        end else begin
            case (opcode)
                OP_J: begin
                    ctrl.s_inc = 1'b0;
                    ctrl.pc_we = 1'b1;
                end
                OP_JZ: begin
                    ctrl.s_inc = ~zero;
                    ctrl.pc_we = 1'b1;
                end
                OP_JNZ: begin
                    ctrl.s_inc = zero;
                    ctrl.pc_we = 1'b1;
                end
                OP_NOP: begin
                    ctrl.pc_we = 1'b1;
                end
                // PC is not advanced so it keeps pointing at the HALT word
                OP_HALT: begin
                    halt_op = 1'b1;
                end
                // Undefined 11xxxx: behave as NOP but flag it
                default: begin
                    ctrl.pc_we = 1'b1;
                    illegal_op = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: FETCH/EXEC sequencing with run/step debug, HALT, illegal flag, retire counter.
// Latency: 2 cycles per instruction free-running; step_ack registered one cycle after the stepped EXEC.
// Backpressure: none; step_req is honoured only in IDLE with run low and is never queued.
// Ports: clk, reset (sync, active-low); Opcode/zero from datapath; run/step_req debug inputs;
//        s_inc, s_inm, we, wez, ALUOp, pc_we to datapath; halted, step_ack, illegal, instr_count status.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             run,
    input  logic             step_req,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_we,
    output logic             halted,
    output logic             step_ack,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, state_nxt;
    logic   single, single_nxt;
    ctrl_t  dec_ctrl, ctrl_act;
    logic   dec_illegal, dec_halt;
    logic   in_exec;

    uc_decoder u_decoder (
        .opcode     (Opcode),
        .zero       (zero),
        .ctrl       (dec_ctrl),
        .illegal_op (dec_illegal),
        .halt_op    (dec_halt)
    );

    assign in_exec = (state == EXEC);

    // Reset gating keeps the datapath from writing on the reset edge itself
    assign ctrl_act = (in_exec && reset) ? dec_ctrl : CTRL_DEFAULT;

    assign s_inc = ctrl_act.s_inc;
    assign s_inm = ctrl_act.s_inm;
    assign we    = ctrl_act.we;
    assign wez   = ctrl_act.wez;
    assign ALUOp = ctrl_act.alu_op;
    assign pc_we = ctrl_act.pc_we;

    always_comb begin
        state_nxt  = state;
        single_nxt = single;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt  = FETCH;
                    single_nxt = 1'b0;
                end else if (step_req) begin
                    state_nxt  = FETCH;
                    single_nxt = 1'b1;
                end
            end
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (dec_halt) begin
                    state_nxt = HALT;
                end else if (single || !run) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            single      <= 1'b0;
            halted      <= 1'b0;
            step_ack    <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state    <= state_nxt;
            single   <= single_nxt;
            halted   <= (state_nxt == HALT);
            // A non-HALT EXEC with single set always returns to IDLE
            step_ack <= in_exec && !dec_halt && single;
            illegal  <= in_exec && dec_illegal;
            if (in_exec && !dec_halt) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Testbench for uc_multiciclo: directed scenarios with literal expectations plus randomized stimulus,
// all checked every cycle against an instruction-level behavioural model.
// Counter width is reduced so the wrap-around is reachable in a short run.
module tb_uc_multiciclo;

    localparam int TB_CNT_W = 8;
    localparam logic [2:0] TB_ALUOP_LI = 3'b111;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [5:0]          Opcode = 6'b000100;
    logic                zero = 1'b0;
    logic                run = 1'b1;
    logic                step_req = 1'b0;
    logic                s_inc, s_inm, we, wez, pc_we;
    logic [2:0]          ALUOp;
    logic                halted, step_ack, illegal;
    logic [TB_CNT_W-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    uc_multiciclo #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .Opcode      (Opcode),
        .zero        (zero),
        .run         (run),
        .step_req    (step_req),
        .s_inc       (s_inc),
        .s_inm       (s_inm),
        .we          (we),
        .wez         (wez),
        .ALUOp       (ALUOp),
        .pc_we       (pc_we),
        .halted      (halted),
        .step_ack    (step_ack),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting, 1 memory wait, 2 executing, 3 stopped
    int m_phase = 0;
    bit m_single = 1'b0;
    bit m_halted = 1'b0;
    bit m_ack = 1'b0;
    bit m_ill = 1'b0;
    int m_cnt = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase  <= 0;
            m_single <= 1'b0;
            m_halted <= 1'b0;
            m_ack    <= 1'b0;
            m_ill    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_ack    <= 1'b0;
            m_ill    <= 1'b0;
            m_halted <= (m_phase == 3) || (m_phase == 2 && Opcode == 6'd63);
            case (m_phase)
                0: begin
                    if (run) begin
                        m_phase <= 1; m_single <= 1'b0;
                    end else if (step_req) begin
                        m_phase <= 1; m_single <= 1'b1;
                    end
                end
                1: m_phase <= 2;
                2: begin
                    if (Opcode == 6'd63) begin
                        m_phase <= 3;
                    end else begin
                        m_cnt   <= (m_cnt + 1) % (1 << TB_CNT_W);
                        m_ill   <= (Opcode >= 6'd52);
                        m_ack   <= m_single;
                        m_phase <= (m_single || !run) ? 0 : 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Expected {s_inc, s_inm, we, wez, ALUOp, pc_we} from instruction class arithmetic
    function automatic logic [8:0] exp_ctrl(input int ph, input int op, input logic z, input logic rst);
        logic       e_inc, e_inm, e_we, e_wez, e_pcwe;
        logic [2:0] e_alu;
        e_inc = 1'b1; e_inm = 1'b0; e_we = 1'b0; e_wez = 1'b0; e_alu = 3'b000; e_pcwe = 1'b0;
        if (rst && ph == 2) begin
            if (op < 32) begin
                e_alu = 3'((op / 4) % 8); e_we = 1'b1; e_wez = 1'b1; e_pcwe = 1'b1;
            end else if (op < 48) begin
                e_alu = TB_ALUOP_LI; e_inm = 1'b1; e_we = 1'b1; e_pcwe = 1'b1;
            end else if (op == 48) begin
                e_inc = 1'b0; e_pcwe = 1'b1;
            end else if (op == 49) begin
                e_inc = !z; e_pcwe = 1'b1;
            end else if (op == 50) begin
                e_inc = z; e_pcwe = 1'b1;
            end else if (op != 63) begin
                e_pcwe = 1'b1;
            end
        end
        return {e_inc, e_inm, e_we, e_wez, e_alu, e_pcwe};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("ctrl", {23'd0, s_inc, s_inm, we, wez, ALUOp, pc_we},
                  {23'd0, exp_ctrl(m_phase, int'(Opcode), zero, reset)});
            check("halted", 32'(halted), 32'(m_halted));
            check("step_ack", 32'(step_ack), 32'(m_ack));
            check("illegal", 32'(illegal), 32'(m_ill));
            check("instr_count", 32'(instr_count), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset hold with an ALU op present and run high
        tick();
        started = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_writes", {29'd0, we, wez, pc_we}, 32'd0);
            check("rst_count", 32'(instr_count), 32'd0);
            tick();
        end
        reset = 1'b1;
        Opcode = 6'b000110;
        tick();                                   // FETCH
        #1 check("fetch_pc_we", 32'(pc_we), 32'd0);
        tick();                                   // EXEC of ALU op
        #1 check("alu_ctrl", {23'd0, s_inc, s_inm, we, wez, ALUOp, pc_we}, 32'b1_0_1_1_001_1);
        check("alu_cnt_before", 32'(instr_count), 32'd0);
        Opcode = 6'b110001;
        zero = 1'b1;
        tick();                                   // FETCH
        #1 check("alu_cnt_after", 32'(instr_count), 32'd1);
        tick();                                   // EXEC JZ, zero=1
        #1 check("jz_taken", {30'd0, s_inc, pc_we}, 32'b01);
        tick();                                   // FETCH
        zero = 1'b0;
        tick();                                   // EXEC JZ, zero=0
        #1 check("jz_not_taken", {30'd0, s_inc, pc_we}, 32'b11);
        tick();                                   // FETCH
        run = 1'b0;
        tick();                                   // EXEC completes despite run low
        tick();                                   // IDLE
        #1 check("run_drop_ack", 32'(step_ack), 32'd0);
        check("run_drop_cnt", 32'(instr_count), 32'd4);

        // Single step
        Opcode = 6'b110011;
        step_req = 1'b1;
        tick();                                   // FETCH
        step_req = 1'b0;
        tick();                                   // EXEC
        step_req = 1'b1;                          // must be ignored
        tick();                                   // IDLE
        step_req = 1'b0;
        #1 check("step_ack_hi", 32'(step_ack), 32'd1);
        check("step_cnt", 32'(instr_count), 32'd5);
        tick();
        #1 check("step_ack_lo", 32'(step_ack), 32'd0);
        tick();
        #1 check("step_ignored", 32'(instr_count), 32'd5);

        // Undefined opcode
        run = 1'b1;
        Opcode = 6'b110101;
        tick();                                   // FETCH
        tick();                                   // EXEC
        #1 check("illegal_ctrl", {30'd0, s_inc, pc_we}, 32'b11);
        check("illegal_pre", 32'(illegal), 32'd0);
        tick();                                   // FETCH
        #1 check("illegal_pulse", 32'(illegal), 32'd1);
        check("illegal_cnt", 32'(instr_count), 32'd6);
        tick();                                   // EXEC
        #1 check("illegal_clear", 32'(illegal), 32'd0);

        // Counter wrap
        Opcode = 6'b110011;
        for (int i = 0; i < 1200 && instr_count != 8'hFF; i++) tick();
        check("reach_ff", 32'(instr_count), 32'hFF);
        tick();                                   // EXEC
        tick();                                   // FETCH
        #1 check("wrap_zero", 32'(instr_count), 32'd0);

        // HALT
        Opcode = 6'b111111;
        tick();                                   // EXEC HALT
        #1 check("halt_pc_we", 32'(pc_we), 32'd0);
        check("halt_pre", 32'(halted), 32'd0);
        tick();
        step_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("halt_sticky", 32'(halted), 32'd1);
            check("halt_cnt", 32'(instr_count), 32'd0);
            tick();
        end
        step_req = 1'b0;
        reset = 1'b0;
        tick();
        #1 check("halt_reset", 32'(halted), 32'd0);
        reset = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset    = ($urandom_range(0, 39) != 0);
            run      = ($urandom_range(0, 3) != 0);
            step_req = ($urandom_range(0, 2) == 0);
            Opcode   = 6'($urandom_range(0, 63));
            zero     = 1'($urandom_range(0, 1));
        end
        tick();
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
